// File: rtl/palmpilot_pkg.sv
// Shared types and glyph table for the difficulty display.
// Glyphs are active-low in {g,f,e,d,c,b,a} order.
package palmpilot_pkg;

    typedef enum logic [1:0] {
        SELECT    = 2'd0,
        HANDSHAKE = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam logic [1:0] LVL_EASY = 2'd0;
    localparam logic [1:0] LVL_MED  = 2'd1;
    localparam logic [1:0] LVL_HARD = 2'd2;

    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_S     = 7'b0010010;
    localparam logic [6:0] GLYPH_Y     = 7'b0010001;
    localparam logic [6:0] GLYPH_N     = 7'b0101011;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_H     = 7'b0001001;
    localparam logic [6:0] GLYPH_R     = 7'b0101111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Returns {char0, char1, char2, char3}; char0 is the leftmost digit.
    function automatic logic [27:0] level_text(input logic [1:0] sel);
        logic [27:0] txt;
        txt = {GLYPH_DASH, GLYPH_DASH, GLYPH_DASH, GLYPH_DASH};
        case (sel)
            2'd0:    txt = {GLYPH_E, GLYPH_A, GLYPH_S, GLYPH_Y};
            2'd1:    txt = {GLYPH_N, GLYPH_E, GLYPH_D, GLYPH_BLANK};
            2'd2:    txt = {GLYPH_H, GLYPH_A, GLYPH_R, GLYPH_D};
            default: txt = {GLYPH_DASH, GLYPH_DASH, GLYPH_DASH, GLYPH_DASH};
        endcase
        return txt;
    endfunction

endpackage

// File: rtl/seg_mux4.sv
// Four-digit time-multiplexer: refresh counter, digit index and registered
// anode/segment drive. blank forces every anode and segment off.
module seg_mux4
    import palmpilot_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] char0,
    input  logic [6:0] char1,
    input  logic [6:0] char2,
    input  logic [6:0] char3,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int              CW           = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   REFRESH_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

    always_comb begin
        an_next  = 4'b1111;
        seg_next = GLYPH_BLANK;
        case (digit_idx)
            2'd0: begin an_next = 4'b0111; seg_next = char0; end
            2'd1: begin an_next = 4'b1011; seg_next = char1; end
            2'd2: begin an_next = 4'b1101; seg_next = char2; end
            default: begin an_next = 4'b1110; seg_next = char3; end
        endcase
        if (blank) begin
            an_next  = 4'b1111;
            seg_next = GLYPH_BLANK;
        end
    end

    // Registered drive keeps the pins glitch-free across digit changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= GLYPH_BLANK;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: rtl/difficulty_display.sv
// Blinks the live difficulty while the player chooses, then latches it,
// shows it solid and raises game_start until the game core acks.
module difficulty_display
    import palmpilot_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] selection,
    input  logic       done,
    input  logic       game_ack,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       game_start,
    output logic [1:0] level,
    output state_t     dbg_state
);

    // Handshake: game_start rises with the level latch and holds until
    // game_ack is sampled high; dropping done aborts it at any time.

    localparam int            BW         = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    state_t        state, state_next;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic [1:0]    sel_prev;
    logic [1:0]    text_sel;
    logic [27:0]   text;
    logic          blank;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SELECT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SELECT:    if (done) state_next = HANDSHAKE;
            HANDSHAKE: begin
                if (!done)         state_next = SELECT;
                else if (game_ack) state_next = RUN;
            end
            RUN:       if (!done) state_next = SELECT;
            default:   state_next = SELECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= LVL_EASY;
        end else if (state == SELECT && done) begin
            level <= (selection == 2'd3) ? LVL_HARD : selection;
        end
    end

    // A fresh selection restarts the blink in its lit phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            sel_prev  <= 2'd0;
        end else begin
            sel_prev <= selection;
            if (state != SELECT || selection != sel_prev) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        game_start = (state == HANDSHAKE);
        dp         = 1'b1;
        dbg_state  = state;
        text_sel   = (state == SELECT) ? selection : level;
        blank      = (state == SELECT) && !blink_on;
        text       = level_text(text_sel);
    end

    seg_mux4 #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_mux (
        .clk   (clk),
        .reset (reset),
        .char0 (text[27:21]),
        .char1 (text[20:14]),
        .char2 (text[13:7]),
        .char3 (text[6:0]),
        .blank (blank),
        .seg   (seg),
        .an    (an)
    );

endmodule

// File: doc/difficulty_display.md
Name: difficulty_display

Overview:
- Consumes the difficulty selector's `selection`/`done` outputs and drives the Basys 3 4-digit seven-segment display.
- While the player is choosing, it blinks the current level name ("EASY"/"nEd "/"HArd").
- Once `done` is seen, it latches the level, shows it solid, and runs a start/ack handshake with the game core.
- Sits between the difficulty selector and the top-level display pins / game core.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit is lit before the mux advances (1 ms at 100 MHz).
- BLINK_DIV, 25000000, clk cycles per blink phase toggle (2 Hz blink at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high.
- selection  in  2  current difficulty from the selector: 0 easy, 1 medium, 2 hard, 3 illegal.
- done  in  1  selector has confirmed its choice; level-sensitive, sticky high.
- game_ack  in  1  game core has accepted the level.
- seg  out  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}.
- an  out  4  anodes, active-low; an[3] is the leftmost digit.
- dp  out  1  decimal point, active-low; always 1.
- game_start  out  1  request to game core, level-held until acked.
- level  out  2  latched difficulty, stable while game_start=1 and in RUN.

Behaviour:
- Reset (async, active-high):
  - State: state=SELECT, refresh_cnt=0, digit_idx=0, blink_cnt=0, blink_on=1.
  - Outputs: an=4'b1111, seg=7'b1111111, dp=1, game_start=0, level=0.
- Refresh mux:
  - refresh_cnt counts 0..REFRESH_DIV-1.
  - On wrap, digit_idx increments 0,1,2,3,0.
  - digit_idx 0 drives an=4'b0111 with char0; idx 1 drives 4'b1011/char1; idx 2 drives 4'b1101/char2; idx 3 drives 4'b1110/char3.
- Output timing: an/seg are registered, one cycle after the digit_idx/state they reflect.
- Text source:
  - In SELECT the text comes from the live `selection`; in HANDSHAKE/RUN it comes from `level`.
  - sel 0 → E,A,S,Y; sel 1 → n,E,d,blank; sel 2 → H,A,r,d; sel 3 → -,-,-,-.
- Blink:
  - Active in SELECT only. blink_cnt counts 0..BLINK_DIV-1 and blink_on toggles on wrap.
  - When blink_on=0, an=4'b1111.
  - Any change of `selection` in SELECT resets blink_cnt=0 and blink_on=1 on the next cycle, so the new choice shows immediately.
  - In HANDSHAKE/RUN, blink_cnt is held at 0 and the display is solid.
- FSM:
  - SELECT → HANDSHAKE when done=1. On the same edge: latch level = (selection==3 ? 2 : selection) and set game_start=1.
  - HANDSHAKE → RUN when game_ack=1. game_start goes to 0 on the same edge.
  - HANDSHAKE or RUN → SELECT when done=0. game_start=0, blink_on=1, blink_cnt=0; level keeps its last value.
  - If done=0 and game_ack=1 in the same cycle, done=0 wins.
  - game_ack is ignored in SELECT and RUN.
  - Illegal `selection` in SELECT displays "----" and blinks normally.
- Latency:
  - done sampled at edge N → game_start=1 and level valid after edge N.
  - game_ack sampled at edge M → game_start=0 after edge M.
- Reset mid-operation:
  - Blanks the display immediately.
  - Drops game_start asynchronously; no ack is expected afterwards.
- Counter widths come from $clog2(DIV); DIV ≥ 2 is required.

Decomposition:
- Package `palmpilot_pkg` holds:
  - State enum: SELECT, HANDSHAKE, RUN.
  - Level constants: LVL_EASY=0, LVL_MED=1, LVL_HARD=2.
  - Glyph localparams (active-low gfedcba):
    - letters: E=0000110, A=0001000, S=0010010, Y=0010001, n=0101011, d=0100001, H=0001001, r=0101111
    - symbols: dash=0111111, blank=1111111
- Sub-module `seg_mux4` holds the refresh counter, digit_idx, and anode/segment selection from four glyph inputs plus a blank enable. The FSM, blink logic and handshake stay in the top module.

Test Plan:
- Use REFRESH_DIV=4 and BLINK_DIV=16 throughout.
- Reset → an=1111, seg=1111111, game_start=0, level=0. After release, first lit digit has an=0111, seg=0000110 (E) for selection=0.
- selection=2 steady, done=0 → an cycles through 0111, 1011, 1101, 1110 every 4 clocks with H, A, r, d. The display blanks for 16 clocks out of every 32.
- selection changes 0→1 during a blank phase → display is lit on the next cycle, showing n, E, d, blank.
- selection=1, done rises at edge N → game_start=1 and level=1 after edge N. Display is solid; game_ack at edge N+5 → game_start=0 after N+5, state RUN, level stays 1.
- selection=3 → "----" blinks. done=1 → level=2, display solid "HArd".
- In HANDSHAKE, drive done=0 and game_ack=1 in the same cycle → SELECT, game_start=0, blinking resumes. Separately, assert reset mid-RUN → all outputs return to reset values immediately.
